// File: rtl/fm_write_ctrl.sv
`default_nettype none
// ============================================================================
// fm_write_ctrl : write-side sequencer feeding feature_map_buffer (c/h/w addr)
// Rev 1.0
// ============================================================================
module fm_write_ctrl #(
    parameter int OUT_H = 64,
    parameter int OUT_W = 64,
    parameter int OUT_C = 32,
    parameter int CH_W  = 10,
    parameter int HW_W  = 7,
    parameter int ORDER = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [7:0]      data_in,
    output logic            write_en,
    output logic [CH_W-1:0] write_ch,
    output logic [HW_W-1:0] write_h,
    output logic [HW_W-1:0] write_w,
    output logic [7:0]      fm_data,
    output logic            busy,
    output logic            done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CH_W-1:0] C_LAST_C = CH_W'(OUT_C - 1);
    localparam logic [HW_W-1:0] C_LAST_H = HW_W'(OUT_H - 1);
    localparam logic [HW_W-1:0] C_LAST_W = HW_W'(OUT_W - 1);

    logic [0:0]      r_state;
    logic [CH_W-1:0] r_c;
    logic [HW_W-1:0] r_h;
    logic [HW_W-1:0] r_w;
    logic            r_write_en;
    logic [CH_W-1:0] r_write_ch;
    logic [HW_W-1:0] r_write_h;
    logic [HW_W-1:0] r_write_w;
    logic [7:0]      r_fm_data;
    logic            r_done;

    logic            w_accept;
    logic            w_last_c;
    logic            w_last_h;
    logic            w_last_w;
    logic            w_final;
    logic [CH_W-1:0] w_c_next;
    logic [HW_W-1:0] w_h_next;
    logic [HW_W-1:0] w_w_next;

    assign w_accept = valid_in && (r_state == S_RUN);
    assign w_last_c = (r_c == C_LAST_C);
    assign w_last_h = (r_h == C_LAST_H);
    assign w_last_w = (r_w == C_LAST_W);
    assign w_final  = w_last_c && w_last_h && w_last_w;

    // The innermost counter differs per order; the outermost never wraps
    // because the final element returns all counters to zero explicitly.
    generate
        if (ORDER == 0) begin : g_order_chw
            assign w_w_next = w_last_w ? '0 : r_w + 1'b1;
            assign w_h_next = w_last_w ? (w_last_h ? '0 : r_h + 1'b1) : r_h;
            assign w_c_next = (w_last_w && w_last_h) ? r_c + 1'b1 : r_c;
        end else begin : g_order_hwc
            assign w_c_next = w_last_c ? '0 : r_c + 1'b1;
            assign w_w_next = w_last_c ? (w_last_w ? '0 : r_w + 1'b1) : r_w;
            assign w_h_next = (w_last_c && w_last_w) ? r_h + 1'b1 : r_h;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_c        <= '0;
            r_h        <= '0;
            r_w        <= '0;
            r_write_en <= 1'b0;
            r_write_ch <= '0;
            r_write_h  <= '0;
            r_write_w  <= '0;
            r_fm_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_write_en <= w_accept;
            r_done     <= w_accept && w_final;

            if (w_accept) begin
                r_write_ch <= r_c;
                r_write_h  <= r_h;
                r_write_w  <= r_w;
                r_fm_data  <= data_in;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_c     <= '0;
                        r_h     <= '0;
                        r_w     <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_final) begin
                            r_state <= S_IDLE;
                            r_c     <= '0;
                            r_h     <= '0;
                            r_w     <= '0;
                        end else begin
                            r_c     <= w_c_next;
                            r_h     <= w_h_next;
                            r_w     <= w_w_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_out = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign write_en  = r_write_en;
    assign write_ch  = r_write_ch;
    assign write_h   = r_write_h;
    assign write_w   = r_write_w;
    assign fm_data   = r_fm_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fm_write_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fm_write_ctrl : directed bench driving ORDER=0 and ORDER=1 instances
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fm_write_ctrl;

    localparam int OUT_C = 2;
    localparam int OUT_H = 2;
    localparam int OUT_W = 3;
    localparam int CH_W  = 10;
    localparam int HW_W  = 7;
    localparam int N     = OUT_C * OUT_H * OUT_W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            valid_in = 1'b0;
    logic [7:0]      data_in = 8'h00;

    logic            rdy0, we0, busy0, done0;
    logic [CH_W-1:0] ch0;
    logic [HW_W-1:0] h0, w0;
    logic [7:0]      d0;
    logic            rdy1, we1, busy1, done1;
    logic [CH_W-1:0] ch1;
    logic [HW_W-1:0] h1, w1;
    logic [7:0]      d1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fm_write_ctrl #(
        .OUT_H(OUT_H), .OUT_W(OUT_W), .OUT_C(OUT_C),
        .CH_W(CH_W), .HW_W(HW_W), .ORDER(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
        .ready_out(rdy0), .data_in(data_in), .write_en(we0),
        .write_ch(ch0), .write_h(h0), .write_w(w0), .fm_data(d0),
        .busy(busy0), .done(done0)
    );

    fm_write_ctrl #(
        .OUT_H(OUT_H), .OUT_W(OUT_W), .OUT_C(OUT_C),
        .CH_W(CH_W), .HW_W(HW_W), .ORDER(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
        .ready_out(rdy1), .data_in(data_in), .write_en(we1),
        .write_ch(ch1), .write_h(h1), .write_w(w1), .fm_data(d1),
        .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic exp_rdy);
        chk({tag, "_we0"},   32'(we0),   0);
        chk({tag, "_done0"}, 32'(done0), 0);
        chk({tag, "_rdy0"},  32'(rdy0),  32'(exp_rdy));
        chk({tag, "_busy0"}, 32'(busy0), 32'(exp_rdy));
        chk({tag, "_we1"},   32'(we1),   0);
        chk({tag, "_done1"}, 32'(done1), 0);
        chk({tag, "_rdy1"},  32'(rdy1),  32'(exp_rdy));
    endtask

    // Element k: ORDER=0 walks (c,h,w), ORDER=1 walks (h,w,c).
    task automatic chk_write(input string tag, input int k, input logic [7:0] d);
        string t;
        logic  last;
        t    = $sformatf("%s[%0d]", tag, k);
        last = (k == N - 1);
        chk({t, "_we0"},   32'(we0),   1);
        chk({t, "_ch0"},   32'(ch0),   32'(k / (OUT_H * OUT_W)));
        chk({t, "_h0"},    32'(h0),    32'((k / OUT_W) % OUT_H));
        chk({t, "_w0"},    32'(w0),    32'(k % OUT_W));
        chk({t, "_d0"},    32'(d0),    32'(d));
        chk({t, "_done0"}, 32'(done0), 32'(last));
        chk({t, "_we1"},   32'(we1),   1);
        chk({t, "_ch1"},   32'(ch1),   32'(k % OUT_C));
        chk({t, "_h1"},    32'(h1),    32'(k / (OUT_C * OUT_W)));
        chk({t, "_w1"},    32'(w1),    32'((k / OUT_C) % OUT_W));
        chk({t, "_d1"},    32'(d1),    32'(d));
        chk({t, "_done1"}, 32'(done1), 32'(last));
    endtask

    task automatic start_pass(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_rdy0"},  32'(rdy0),  1);
        chk({tag, "_busy0"}, 32'(busy0), 1);
        chk({tag, "_rdy1"},  32'(rdy1),  1);
        chk({tag, "_we0"},   32'(we0),   0);
    endtask

    // Back-to-back stream; leaves valid_in high on return.
    task automatic stream(input string tag, input logic [7:0] base, input int count);
        for (int k = 0; k < count; k++) begin
            valid_in = 1'b1;
            data_in  = base + 8'(k);
            tick();
            chk_write(tag, k, base + 8'(k));
        end
    endtask

    initial begin
        int  k;
        int  cyc;
        logic acc;

        // Reset held low with random inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom_range(0, 1));
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom_range(0, 255));
            tick();
            chk_quiet($sformatf("rst%0d", i), 1'b0);
            chk("rst_ch0", 32'(ch0), 0);
            chk("rst_h0",  32'(h0),  0);
            chk("rst_w0",  32'(w0),  0);
            chk("rst_d0",  32'(d0),  0);
            chk("rst_d1",  32'(d1),  0);
        end

        // Released without start: valid held high must not be consumed
        rst      = 1'b1;
        start    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet($sformatf("nostart%0d", i), 1'b0);
        end
        valid_in = 1'b0;

        // Full back-to-back pass, both orders
        start_pass("a_start");
        stream("a", 8'h01, N);
        tick();
        chk_quiet("a_after", 1'b0);
        valid_in = 1'b0;
        tick();

        // Random bubbles with a stray start mid-pass
        start_pass("b_start");
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            valid_in = 1'($urandom_range(0, 1));
            start    = (cyc == 5);
            data_in  = 8'h40 + 8'(k);
            acc      = valid_in && rdy0;
            tick();
            cyc++;
            if (acc) begin
                chk_write("b", k, 8'h40 + 8'(k));
                k++;
            end else begin
                chk($sformatf("b_bubble_we0_c%0d", cyc), 32'(we0), 0);
                chk($sformatf("b_bubble_done0_c%0d", cyc), 32'(done0), 0);
            end
        end
        start    = 1'b0;
        valid_in = 1'b0;
        chk("b_count", 32'(k), 32'(N));
        tick();
        chk_quiet("b_after", 1'b0);

        // Abort after 5 writes, then a fresh full pass
        start_pass("c_start");
        stream("c_part", 8'h60, 5);
        valid_in = 1'b0;
        rst      = 1'b0;
        tick();
        chk_quiet("c_rst", 1'b0);
        chk("c_rst_ch0", 32'(ch0), 0);
        chk("c_rst_w0",  32'(w0),  0);
        chk("c_rst_d0",  32'(d0),  0);
        rst = 1'b1;
        tick();
        tick();
        chk_quiet("c_idle", 1'b0);
        start_pass("c_restart");
        stream("c_full", 8'h80, N);

        // Start in the done cycle with valid held high
        start   = 1'b1;
        data_in = 8'hA0;
        tick();
        start = 1'b0;
        chk("d_we0_gap",   32'(we0),   0);
        chk("d_done0_gap", 32'(done0), 0);
        chk("d_rdy0_gap",  32'(rdy0),  1);
        stream("d", 8'hA0, N);
        tick();
        chk_quiet("d_after", 1'b0);
        valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
